// File: rtl/decoder_pkg.sv
// Shared encodings and the one-hot helper for the sequenced N-to-2^N decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'b00,
        MODE_PULSE = 2'b01,
        MODE_SCAN  = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_PULSE,
        ST_SCAN
    } state_t;

    // Widest supported select is 8 bits; callers truncate to their 2^N width.
    localparam int unsigned MAX_W = 256;

    function automatic logic [MAX_W-1:0] onehot(input logic [7:0] idx);
        logic [MAX_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Down-counter timing how long a code is held; tc flags the last held cycle.
// load has priority over dec; clr and rst return the count to zero.
module dwell_counter #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic dec,
    output logic tc
);
    localparam int unsigned CW = $clog2(DWELL + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(DWELL);
        end else if (dec && count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign tc = (count == CW'(1));

endmodule

// File: rtl/decoder_n_seq.sv
// N-to-2^N one-hot decoder with LEVEL, PULSE and SCAN modes, 1-cycle registered latency.
// in_ready drops while a pulse is still running, in SCAN/reserved modes and on a mode change.
module decoder_n_seq
    import decoder_pkg::*;
#(
    parameter int unsigned N          = 3,
    parameter int unsigned DWELL      = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                in_valid,
    input  logic [N-1:0]        in_sel,
    output logic                in_ready,
    output logic [(1<<N)-1:0]   out,
    output logic                out_valid,
    output logic [N-1:0]        sel_q,
    output logic                wrap
);
    localparam int unsigned W = 1 << N;

    mode_t          mode_i;
    mode_t          mode_q;
    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   sel_r;
    logic [N-1:0]   sel_nxt;
    logic           wrap_r;
    logic           wrap_nxt;
    logic           mode_chg;
    logic           pulsing;
    logic           xfer;
    logic           tc;
    logic           cnt_load;
    logic           cnt_dec;
    logic           cnt_clr;
    logic [W-1:0]   logic_out;

    assign mode_i   = mode_t'(mode);
    assign mode_chg = (mode_i != mode_q);

    // The final cycle of a pulse counts as not pulsing so back-to-back pulses are gapless.
    // A mode change cycle refuses input because the FSM is about to return to IDLE.
    assign pulsing  = (state == ST_PULSE) && !tc;
    assign in_ready = en && !mode_chg &&
                      ((mode_i == MODE_LEVEL) || ((mode_i == MODE_PULSE) && !pulsing));
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            sel_r  <= '0;
            wrap_r <= 1'b0;
            mode_q <= mode_i;
        end else if (en) begin
            state  <= state_nxt;
            sel_r  <= sel_nxt;
            wrap_r <= wrap_nxt;
            mode_q <= mode_i;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_r;
        wrap_nxt  = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_clr   = 1'b0;
        if (mode_chg) begin
            state_nxt = ST_IDLE;
            sel_nxt   = '0;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    case (mode_i)
                        MODE_LEVEL: begin
                            if (xfer) begin
                                state_nxt = ST_HOLD;
                                sel_nxt   = in_sel;
                            end
                        end
                        MODE_PULSE: begin
                            if (xfer) begin
                                state_nxt = ST_PULSE;
                                sel_nxt   = in_sel;
                                cnt_load  = 1'b1;
                            end
                        end
                        MODE_SCAN: begin
                            state_nxt = ST_SCAN;
                            sel_nxt   = '0;
                            cnt_load  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_HOLD: begin
                    if (xfer) begin
                        sel_nxt = in_sel;
                    end
                end
                ST_PULSE: begin
                    if (!tc) begin
                        cnt_dec = 1'b1;
                    end else if (xfer) begin
                        sel_nxt  = in_sel;
                        cnt_load = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        sel_nxt   = '0;
                        cnt_clr   = 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (tc) begin
                        sel_nxt  = sel_r + N'(1);
                        wrap_nxt = (sel_r == {N{1'b1}});
                        cnt_load = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    sel_nxt   = '0;
                    cnt_clr   = 1'b1;
                end
            endcase
        end
    end

    // Counter actions are gated by en so a disabled block resumes with its remaining dwell.
    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr && en),
        .load (cnt_load && en),
        .dec  (cnt_dec && en),
        .tc   (tc)
    );

    always_comb begin
        out_valid = en && (state != ST_IDLE);
        logic_out = '0;
        sel_q     = '0;
        wrap      = 1'b0;
        if (out_valid) begin
            logic_out = W'(onehot(8'(sel_r)));
            sel_q     = sel_r;
            wrap      = wrap_r && (state == ST_SCAN);
        end
    end

    assign out = ACTIVE_LOW ? ~logic_out : logic_out;

endmodule

// File: tb/tb_decoder_n_seq.sv
// Directed-vector bench for decoder_n_seq: stimulus queues expected outputs per cycle, a monitor compares them.
module tb_decoder_n_seq;

    localparam logic [1:0] LV = 2'b00;
    localparam logic [1:0] PU = 2'b01;
    localparam logic [1:0] SC = 2'b10;
    localparam logic [1:0] RS = 2'b11;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       in_valid;
    logic [2:0] in_sel;

    logic       in_ready,  in_ready_n;
    logic [7:0] out,       out_n;
    logic       out_valid, out_valid_n;
    logic [2:0] sel_q,     sel_q_n;
    logic       wrap,      wrap_n;

    typedef struct {
        logic [7:0] o;
        logic       v;
        logic [2:0] s;
        logic       w;
        logic       r;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    decoder_n_seq #(.N(3), .DWELL(4), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_sel(in_sel),
        .in_ready(in_ready), .out(out), .out_valid(out_valid), .sel_q(sel_q), .wrap(wrap)
    );

    decoder_n_seq #(.N(3), .DWELL(4), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_sel(in_sel),
        .in_ready(in_ready_n), .out(out_n), .out_valid(out_valid_n), .sel_q(sel_q_n), .wrap(wrap_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] oh(input logic [2:0] k);
        logic [7:0] one;
        one = 8'd1;
        return one << k;
    endfunction

    // One cycle of stimulus plus the outputs expected during that same cycle.
    task automatic cyc(input logic r, input logic e, input logic [1:0] m, input logic iv,
                       input logic [2:0] is, input logic ev, input logic [2:0] es,
                       input logic ew, input logic er);
        exp_t x;
        @(posedge clk);
        #1;
        rst      = r;
        en       = e;
        mode     = m;
        in_valid = iv;
        in_sel   = is;
        x.o = ev ? oh(es) : 8'h00;
        x.v = ev;
        x.s = es;
        x.w = ew;
        x.r = er;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        cycle <= cycle + 1;
        if (q.size() != 0) begin
            exp_t x;
            x = q.pop_front();
            checks++;
            if (out !== x.o || out_n !== ~x.o || out_valid !== x.v || out_valid_n !== x.v ||
                sel_q !== x.s || sel_q_n !== x.s || wrap !== x.w || wrap_n !== x.w ||
                in_ready !== x.r || in_ready_n !== x.r) begin
                errors++;
                $display("FAIL cycle%0d: got out=%b out_al=%b vld=%b sel=%0d wrap=%b rdy=%b; want out=%b out_al=%b vld=%b sel=%0d wrap=%b rdy=%b",
                         cycle, out, out_n, out_valid, sel_q, wrap, in_ready,
                         x.o, ~x.o, x.v, x.s, x.w, x.r);
            end
        end
    end

    initial begin
        logic [2:0] prev;
        rst      = 1'b1;
        en       = 1'b1;
        mode     = LV;
        in_valid = 1'b0;
        in_sel   = 3'd0;

        // Reset, then LEVEL decode of every index with 1-cycle latency
        cyc(1, 1, LV, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, LV, 1, 5, 0, 0, 0, 1);
        prev = 3'd5;
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, LV, 1, 3'(k), 1, prev, 0, 1);
            prev = 3'(k);
        end
        cyc(0, 1, LV, 0, 0, 1, 7, 0, 1);
        cyc(0, 1, LV, 0, 0, 1, 7, 0, 1);
        cyc(0, 0, LV, 1, 3, 0, 0, 0, 0);
        cyc(0, 1, LV, 0, 0, 1, 7, 0, 1);

        // PULSE: 4-cycle strobe, ignored request mid-pulse, gapless follow-on
        cyc(0, 1, PU, 0, 0, 1, 7, 0, 0);
        cyc(0, 1, PU, 1, 3, 0, 0, 0, 1);
        cyc(0, 1, PU, 0, 0, 1, 3, 0, 0);
        cyc(0, 1, PU, 1, 6, 1, 3, 0, 0);
        cyc(0, 1, PU, 0, 0, 1, 3, 0, 0);
        cyc(0, 1, PU, 1, 6, 1, 3, 0, 1);
        cyc(0, 1, PU, 0, 0, 1, 6, 0, 0);
        cyc(0, 1, PU, 0, 0, 1, 6, 0, 0);
        cyc(0, 1, PU, 0, 0, 1, 6, 0, 0);
        cyc(0, 1, PU, 0, 0, 1, 6, 0, 1);
        cyc(0, 1, PU, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, PU, 0, 0, 0, 0, 0, 1);

        // SCAN: entry, 8 indices x 4 cycles, wrap 33 cycles after entry
        cyc(0, 1, SC, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, SC, 1, 5, 0, 0, 0, 0);
        for (int j = 0; j < 42; j++)
            cyc(0, 1, SC, 0, 0, 1, 3'((j / 4) % 8), (j == 32), 0);
        // en low for 3 cycles halfway through index 2
        for (int j = 0; j < 3; j++)
            cyc(0, 0, SC, 0, 0, 0, 0, 0, 0);
        for (int j = 42; j < 50; j++)
            cyc(0, 1, SC, 0, 0, 1, 3'((j / 4) % 8), 0, 0);

        // SCAN -> LEVEL at index 4, then reserved mode
        cyc(0, 1, LV, 0, 0, 1, 4, 0, 0);
        cyc(0, 1, LV, 1, 1, 0, 0, 0, 1);
        cyc(0, 1, LV, 0, 0, 1, 1, 0, 1);
        cyc(0, 1, RS, 0, 0, 1, 1, 0, 0);
        cyc(0, 1, RS, 1, 5, 0, 0, 0, 0);
        cyc(0, 1, RS, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a pulse
        cyc(0, 1, PU, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, PU, 1, 2, 0, 0, 0, 1);
        cyc(0, 1, PU, 0, 0, 1, 2, 0, 0);
        cyc(1, 1, PU, 0, 0, 1, 2, 0, 0);
        cyc(0, 1, PU, 0, 0, 0, 0, 0, 1);

        // Reset in the middle of a scan; restart shows index 0 without wrap
        cyc(0, 1, SC, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, SC, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 5; j++)
            cyc(0, 1, SC, 0, 0, 1, 3'(j / 4), 0, 0);
        cyc(1, 1, SC, 0, 0, 1, 1, 0, 0);
        cyc(0, 1, SC, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, SC, 0, 0, 1, 0, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
